amba_ahb_master: RTL and testbench

//  AHB-Lite bus master (initiator) that turns simple command-port requests into
//  AHB transfers: SINGLE, or INCR bursts of 1..16 beats. Pipelined address and

---
 rtl/amba_ahb_master.sv | 156 +++++++++++++++
 tb/tb_amba_ahb_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_master.sv
// AHB-Lite initiator: turns command-port requests into SINGLE / INCR bursts.
// Pipelined address and data phases, wait states and two-cycle ERROR handling.
module amba_ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam int MAXS = $clog2(DATA_W / 8);
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST,
    S_ERR
  } state_t;

  state_t            state;
  logic [3:0]        left;
  logic              dp_act;
  logic              dp_last;
  logic              dp_wr;
  logic [2:0]        size_c;
  logic [4:0]        len_c;
  logic [ADDR_W-1:0] amask;
  logic [ADDR_W-1:0] nxt_addr;

  always_comb begin
    size_c   = (cmd_size > 3'(MAXS)) ? 3'(MAXS) : cmd_size;
    len_c    = (cmd_len == 5'd0) ? 5'd1 :
               (cmd_len > 5'd16) ? 5'd16 : cmd_len;
    amask    = ~((ADDR_W'(1) << size_c) - ADDR_W'(1));
    nxt_addr = haddr + (ADDR_W'(1) << hsize);
  end

  assign cmd_ready = hresetn & (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wdata_pop = (state == S_ADDR) & hwrite & hready;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      left      <= '0;
      dp_act    <= 1'b0;
      dp_last   <= 1'b0;
      dp_wr     <= 1'b0;
      haddr     <= '0;
      htrans    <= T_IDLE;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hburst    <= '0;
      hprot     <= '0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      hprot     <= 4'b0011;
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state  <= S_ADDR;
            haddr  <= cmd_addr & amask;
            htrans <= T_NSEQ;
            hwrite <= cmd_write;
            hsize  <= size_c;
            hburst <= (len_c == 5'd1) ? 3'b000 : 3'b001;
            left   <= 4'(len_c - 5'd1);
          end
        end
        S_ADDR, S_LAST: begin
          if (dp_act && hresp) begin
            htrans <= T_IDLE;
            if (!hready) begin
              state <= S_ERR;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              rsp_last  <= 1'b1;
              dp_act    <= 1'b0;
              state     <= S_IDLE;
            end
          end else if (hready) begin
            if (dp_act) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= dp_wr ? '0 : hrdata;
              rsp_error <= 1'b0;
              rsp_last  <= dp_last;
            end
            if (state == S_LAST) begin
              dp_act <= 1'b0;
              state  <= S_IDLE;
            end else begin
              dp_act  <= 1'b1;
              dp_last <= (left == 4'd0);
              dp_wr   <= hwrite;
              if (hwrite) hwdata <= wdata;
              if (left == 4'd0) begin
                state  <= S_LAST;
                htrans <= T_IDLE;
              end else begin
                // a beat landing on a 1KB boundary restarts as NONSEQ
                haddr  <= nxt_addr;
                htrans <= (nxt_addr[9:0] == 10'd0) ? T_NSEQ : T_SEQ;
                left   <= left - 4'd1;
              end
            end
          end
        end
        S_ERR: begin
          if (hready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            rsp_last  <= 1'b1;
            dp_act    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba_ahb_master.sv
// Bench for amba_ahb_master: memory slave with waits/errors, queue scoreboard
// fed by a transaction-level model of each command.
module tb_amba_ahb_master;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_last;
  logic        busy;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  always #5 hclk = ~hclk;

  amba_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_last(rsp_last),
    .busy(busy), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  t;
    logic        w;
    logic [2:0]  s;
    logic [2:0]  b;
  } ap_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        l;
  } rs_t;

  ap_t aq[$];
  rs_t rq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [7:0]  ref_mem [0:8191];
  logic [7:0]  slv_mem [0:8191];
  logic [31:0] wbuf [0:15];
  logic [3:0]  widx = '0;
  int          wst [0:15];
  int          err_beat = -1;
  int          sbeat = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          fa_cyc = -1;
  int          fr_cyc = -1;

  assign wdata = wbuf[widx];

  always @(posedge hclk) begin
    cyc = cyc + 1;
    if (wdata_pop) widx <= widx + 4'd1;
  end

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [12:0] b;
    b = a[12:0] & 13'h1FFC;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] slv_word(logic [31:0] a);
    logic [12:0] b;
    b = a[12:0] & 13'h1FFC;
    return {slv_mem[b+3], slv_mem[b+2], slv_mem[b+1], slv_mem[b]};
  endfunction

  task automatic ref_wr(logic [31:0] a, int s, logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) begin
      logic [31:0] x;
      x = a + i;
      ref_mem[x[12:0]] = d[8*x[1:0] +: 8];
    end
  endtask

  task automatic slv_wr(logic [31:0] a, int s, logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) begin
      logic [31:0] x;
      x = a + i;
      slv_mem[x[12:0]] = d[8*x[1:0] +: 8];
    end
  endtask

  task automatic fill_w();
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
  endtask

  task automatic clr_wst();
    for (int k = 0; k < 16; k++) wst[k] = 0;
  endtask

  // model: expected address phases and responses of one whole command
  task automatic launch(bit w, logic [31:0] a, int sz, int len, int eb);
    int s, n, na, tmo;
    logic [31:0] base, ak;
    ap_t ap;
    rs_t rs;
    s    = (sz > 2) ? 2 : sz;
    n    = (len == 0) ? 1 : ((len > 16) ? 16 : len);
    base = a & ~((32'd1 << s) - 32'd1);
    if (eb >= n) eb = -1;
    na   = (eb >= 0) ? eb + 1 : n;
    for (int k = 0; k < na; k++) begin
      ak   = base + k * (1 << s);
      ap.a = ak;
      ap.t = (k == 0 || ak[9:0] == 10'd0) ? 2'b10 : 2'b11;
      ap.w = w;
      ap.s = 3'(s);
      ap.b = (n == 1) ? 3'b000 : 3'b001;
      aq.push_back(ap);
      rs.d = (w || k == eb) ? 32'd0 : ref_word(ak);
      rs.e = (k == eb);
      rs.l = (k == na - 1);
      rq.push_back(rs);
      if (w && k != eb) ref_wr(ak, s, wbuf[k]);
    end
    tmo = 0;
    while (!cmd_ready && tmo < 50) begin
      @(negedge hclk);
      tmo++;
    end
    if (!cmd_ready) fail("cmd_ready_timeout");
    widx      = '0;
    err_beat  = eb;
    sbeat     = 0;
    fa_cyc    = -1;
    fr_cyc    = -1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = 3'(sz);
    cmd_len   = 5'(len);
    @(negedge hclk);
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((busy || aq.size() != 0 || rq.size() != 0) && t < 400) begin
      @(negedge hclk);
      t++;
    end
    check("drain", 128'({busy, 32'(aq.size()), 32'(rq.size())}), '0);
    @(negedge hclk);
  endtask

  // memory slave; decides hready/hresp for the coming edge
  logic        sdp_act = 1'b0;
  logic        sdp_w;
  logic        sdp_err;
  logic        serr2 = 1'b0;
  logic [31:0] sdp_a;
  logic [2:0]  sdp_s;
  int          sdp_k;
  int          swait;

  always @(negedge hclk) begin
    if (!hresetn) begin
      hready  = 1'b1;
      hresp   = 1'b0;
      sdp_act = 1'b0;
      serr2   = 1'b0;
    end else begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = $urandom;
      if (sdp_act) begin
        if (sdp_err) begin
          hresp  = 1'b1;
          hready = serr2;
          serr2  = !serr2;
        end else if (swait > 0) begin
          hready = 1'b0;
          swait--;
        end else if (sdp_w) begin
          check("hwdata", 128'(hwdata), 128'(wbuf[sdp_k & 15]));
          slv_wr(sdp_a, int'(sdp_s), hwdata);
        end else begin
          hrdata = slv_word(sdp_a);
        end
      end
      if (hready) begin
        if (htrans[1]) begin
          sdp_act = 1'b1;
          sdp_a   = haddr;
          sdp_w   = hwrite;
          sdp_s   = hsize;
          sdp_k   = sbeat;
          sdp_err = (sbeat == err_beat);
          swait   = wst[sbeat & 15];
          sbeat++;
        end else begin
          sdp_act = 1'b0;
        end
      end
    end
  end

  // address-phase monitor
  logic         p_hold = 1'b0;
  logic [72:0]  p_snap;
  ap_t          ae;

  always @(negedge hclk) begin
    #1;
    if (hresetn) begin
      if (p_hold)
        check("hold", 128'({haddr, htrans, hwrite, hsize, hburst, hwdata}),
              128'(p_snap));
      if (hresp && hready)
        check("err2_idle", 128'(htrans), 128'(2'b00));
      if (hready && htrans != 2'b00) begin
        if (aq.size() == 0) begin
          fail("addr_unexpected");
        end else begin
          ae = aq.pop_front();
          check("addr_phase", 128'({haddr, htrans, hwrite, hsize, hburst}),
                128'(ae));
          if (fa_cyc < 0) fa_cyc = cyc;
        end
      end
      p_hold = !hready && !hresp;
      p_snap = {haddr, htrans, hwrite, hsize, hburst, hwdata};
    end else begin
      p_hold = 1'b0;
    end
  end

  // response monitor
  rs_t re;

  always @(negedge hclk) begin
    if (hresetn && rsp_valid) begin
      if (rq.size() == 0) begin
        fail("rsp_unexpected");
      end else begin
        re = rq.pop_front();
        check("rsp", 128'({rsp_rdata, rsp_error, rsp_last}), 128'(re));
        if (fr_cyc < 0) fr_cyc = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    clr_wst();
    fill_w();
    #2 hresetn = 1'b0;
    #1;
    check("reset_outs", 128'({cmd_ready, wdata_pop, rsp_valid, rsp_rdata,
          rsp_error, rsp_last, busy, haddr, htrans, hwrite, hsize, hburst,
          hprot, hwdata}), '0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check("ready_after_reset", 128'({cmd_ready, busy}), 128'(2'b10));

    fill_w();
    wbuf[0] = 32'hDEAD_BEEF;
    launch(1'b1, 32'h10, 2, 1, -1);
    check("ready_when_busy", 128'(cmd_ready), '0);
    wait_done();
    // NONSEQ in the cycle after the accept edge, response two cycles later
    check("lat_addr", 128'(fa_cyc - acc_cyc), 128'(0));
    check("lat_rsp", 128'(fr_cyc - acc_cyc), 128'(2));
    launch(1'b0, 32'h10, 2, 1, -1);
    wait_done();

    for (int k = 0; k < 4; k++) begin
      ref_wr(32'h100 + 4 * k, 2, 32'(k + 1));
      slv_wr(32'h100 + 4 * k, 2, 32'(k + 1));
    end
    launch(1'b0, 32'h100, 2, 4, -1);
    wait_done();

    fill_w();
    wst[1] = 2;
    launch(1'b1, 32'h200, 2, 4, -1);
    wait_done();
    clr_wst();
    launch(1'b0, 32'h200, 2, 4, -1);
    wait_done();

    fill_w();
    launch(1'b1, 32'h300, 2, 4, 1);
    wait_done();
    launch(1'b0, 32'h300, 2, 4, -1);
    wait_done();

    launch(1'b0, 32'h3FC, 2, 3, -1);
    wait_done();
    fill_w();
    launch(1'b1, 32'h40, 2, 0, -1);
    wait_done();
    fill_w();
    launch(1'b1, 32'hFFFF_FFF8, 2, 4, -1);
    wait_done();
    launch(1'b0, 32'h13, 7, 2, -1);
    wait_done();

    for (int n = 0; n < 40; n++) begin
      fill_w();
      for (int k = 0; k < 16; k++)
        wst[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      launch(1'($urandom_range(0, 1)), $urandom & 32'h7FF,
             $urandom_range(0, 4), $urandom_range(0, 16),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1);
      wait_done();
    end
    clr_wst();

    for (int k = 0; k < 16; k++) wst[k] = 1;
    launch(1'b0, 32'h500, 2, 16, -1);
    repeat (6) @(negedge hclk);
    #2 hresetn = 1'b0;
    #1;
    check("reset_mid", 128'({cmd_ready, wdata_pop, rsp_valid, rsp_rdata,
          rsp_error, rsp_last, busy, haddr, htrans, hwrite, hsize, hburst,
          hprot, hwdata}), '0);
    aq.delete();
    rq.delete();
    sdp_act = 1'b0;
    hready  = 1'b1;
    hresp   = 1'b0;
    clr_wst();
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check("ready_after_mid_reset", 128'({cmd_ready, busy}), 128'(2'b10));
    launch(1'b0, 32'h100, 2, 4, -1);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
